// File: rtl/pong_pkg.sv
// Shared match-level types and default frame counts for the pong game blocks.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SERVE,
    ST_PLAY,
    ST_POINT,
    ST_GAME_OVER
  } match_state_t;

  localparam logic PLAYER_L = 1'b0;
  localparam logic PLAYER_R = 1'b1;

  localparam int unsigned SERVE_FRAMES_DEF    = 60;
  localparam int unsigned GAMEOVER_FRAMES_DEF = 180;
  localparam int unsigned WIN_SCORE_DEF       = 9;

endpackage

// File: rtl/match_controller_if.sv
// Game-event inputs and scoreboard/ball control outputs of the match controller.
interface match_controller_if;
  logic fsync;
  logic start_btn;
  logic miss_left;
  logic miss_right;
  logic increment_score [1:0];
  logic board_clear;
  logic ball_enable;
  logic serve_dir;
  logic game_over;
  logic winner;

  modport master (
    output fsync, start_btn, miss_left, miss_right,
    input  increment_score, board_clear, ball_enable, serve_dir, game_over, winner
  );

  modport slave (
    input  fsync, start_btn, miss_left, miss_right,
    output increment_score, board_clear, ball_enable, serve_dir, game_over, winner
  );
endinterface

// File: rtl/match_controller_frame_timer.sv
// 8-bit frame countdown: load, decrement on each fsync, done on the fsync that reaches zero.
module frame_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       fsync,
  output logic       done
);
  logic [7:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (fsync && count != 8'd0)
      count <= count - 8'd1;
  end

  assign done = fsync && !load && (count == 8'd1);
endmodule

// File: rtl/match_controller.sv
// Pong match sequencing: serve delay, point scoring, win detection and game-over hold.
// Optional MATCH_CTRL_AUTOSTART_EN restarts a new match straight from GAME_OVER.
module match_controller
  import pong_pkg::*;
#(
  parameter int unsigned SERVE_FRAMES    = SERVE_FRAMES_DEF,
  parameter int unsigned GAMEOVER_FRAMES = GAMEOVER_FRAMES_DEF,
  parameter int unsigned WIN_SCORE       = WIN_SCORE_DEF
) (
  input logic pixel_clk,
  input logic rst,
  match_controller_if.slave bus
);
  match_state_t state, state_next;
  logic [3:0]   tally [2];
  logic [3:0]   tally_inc;
  logic         scorer;
  logic         serve_dir;
  logic         winner;
  logic         board_clear;
  logic         start_prev;
  logic         start_rise;
  logic         timer_load;
  logic [7:0]   timer_val;
  logic         timer_done;
  logic         single_miss;
  logic         win_hit;

  assign start_rise  = bus.start_btn && !start_prev;
  assign single_miss = bus.miss_left ^ bus.miss_right;
  assign tally_inc   = tally[scorer] + 4'd1;
  assign win_hit     = (tally_inc == 4'(WIN_SCORE));

  frame_timer u_timer (
    .clk      (pixel_clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .fsync    (bus.fsync),
    .done     (timer_done)
  );

  always_comb begin
    state_next = state;
    timer_load = 1'b0;
    timer_val  = 8'(SERVE_FRAMES);
    case (state)
      ST_IDLE:
        if (start_rise) begin
          state_next = ST_SERVE;
          timer_load = 1'b1;
        end
      ST_SERVE:
        if (timer_done) state_next = ST_PLAY;
      ST_PLAY:
        if (bus.miss_left && bus.miss_right) begin
          state_next = ST_SERVE;
          timer_load = 1'b1;
        end else if (single_miss) begin
          state_next = ST_POINT;
        end
      ST_POINT:
        if (bus.fsync) begin
          timer_load = 1'b1;
          if (win_hit) begin
            state_next = ST_GAME_OVER;
            timer_val  = 8'(GAMEOVER_FRAMES);
          end else begin
            state_next = ST_SERVE;
          end
        end
      ST_GAME_OVER:
        if (timer_done) begin
`ifdef MATCH_CTRL_AUTOSTART_EN
          state_next = ST_SERVE;
          timer_load = 1'b1;
`else
          state_next = ST_IDLE;
`endif
        end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      tally[0]    <= '0;
      tally[1]    <= '0;
      scorer      <= PLAYER_L;
      serve_dir   <= PLAYER_L;
      winner      <= PLAYER_L;
      board_clear <= 1'b0;
      start_prev  <= 1'b0;
    end else begin
      state       <= state_next;
      start_prev  <= bus.start_btn;
      board_clear <= 1'b0;
      case (state)
        ST_IDLE:
          if (start_rise) begin
            board_clear <= 1'b1;
            tally[0]    <= '0;
            tally[1]    <= '0;
            serve_dir   <= PLAYER_L;
          end
        ST_PLAY:
          // a miss on one side scores for the other; serve goes to the conceder
          if (single_miss) begin
            scorer    <= bus.miss_left ? PLAYER_R : PLAYER_L;
            serve_dir <= bus.miss_left ? PLAYER_L : PLAYER_R;
          end
        ST_POINT:
          if (bus.fsync) begin
            tally[scorer] <= tally_inc;
            if (win_hit) winner <= scorer;
          end
`ifdef MATCH_CTRL_AUTOSTART_EN
        ST_GAME_OVER:
          if (timer_done) begin
            board_clear <= 1'b1;
            tally[0]    <= '0;
            tally[1]    <= '0;
            serve_dir   <= !winner;
          end
`endif
        default: ;
      endcase
    end
  end

  // score request is decoded from state so reset removes it asynchronously
  always_comb begin
    bus.increment_score[0] = (state == ST_POINT) && (scorer == PLAYER_L);
    bus.increment_score[1] = (state == ST_POINT) && (scorer == PLAYER_R);
  end

  assign bus.board_clear = board_clear;
  assign bus.ball_enable = (state == ST_PLAY);
  assign bus.serve_dir   = serve_dir;
  assign bus.game_over   = (state == ST_GAME_OVER);
  assign bus.winner      = winner;
endmodule

// File: tb/tb_match_controller.sv
// Directed self-checking bench for match_controller (SERVE_FRAMES=3, GAMEOVER_FRAMES=4, WIN_SCORE=2).
module tb_match_controller;
  import pong_pkg::*;

  logic pixel_clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   hi_cnt;
  logic bit0_seen;

  match_controller_if bus ();

  match_controller #(
    .SERVE_FRAMES    (3),
    .GAMEOVER_FRAMES (4),
    .WIN_SCORE       (2)
  ) dut (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .bus       (bus.slave)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic fsync_pulse();
    bus.fsync = 1'b1;
    tick();
    bus.fsync = 1'b0;
    tick();
  endtask

  // last tick of the serve countdown lands in PLAY one cycle after the 3rd fsync
  task automatic serve_to_play();
    fsync_pulse();
    fsync_pulse();
    chk("serve_wait_state", 32'(dut.state), 32'(ST_SERVE));
    chk("serve_wait_ball", 32'(bus.ball_enable), 32'd0);
    bus.fsync = 1'b1;
    tick();
    bus.fsync = 1'b0;
    chk("play_state", 32'(dut.state), 32'(ST_PLAY));
    chk("play_ball", 32'(bus.ball_enable), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    bus.fsync = 1'b0;
    bus.start_btn = 1'b0;
    bus.miss_left = 1'b0;
    bus.miss_right = 1'b0;
    tick();
    tick();
    chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
    chk("rst_tally0", 32'(dut.tally[0]), 32'd0);
    chk("rst_tally1", 32'(dut.tally[1]), 32'd0);
    chk("rst_timer", 32'(dut.u_timer.count), 32'd0);
    chk("rst_start_prev", 32'(dut.start_prev), 32'd0);
    chk("rst_inc0", 32'(bus.increment_score[0]), 32'd0);
    chk("rst_inc1", 32'(bus.increment_score[1]), 32'd0);
    chk("rst_outs", {26'd0, bus.board_clear, bus.ball_enable, bus.serve_dir, bus.game_over, bus.winner, 1'b0}, 32'd0);

    rst = 1'b0;
    tick();
    bus.start_btn = 1'b1;
    tick();
    chk("start_state", 32'(dut.state), 32'(ST_SERVE));
    chk("start_clear", 32'(bus.board_clear), 32'd1);
    chk("start_dir", 32'(bus.serve_dir), 32'd0);
    tick();
    chk("start_clear_one", 32'(bus.board_clear), 32'd0);
    bus.start_btn = 1'b0;
    serve_to_play();

    bus.start_btn = 1'b1;
    tick();
    chk("play_btn_state", 32'(dut.state), 32'(ST_PLAY));
    chk("play_btn_clear", 32'(bus.board_clear), 32'd0);
    bus.start_btn = 1'b0;
    tick();

    // left miss: point to player 1, fsync on the 6th POINT cycle
    bus.miss_left = 1'b1;
    tick();
    bus.miss_left = 1'b0;
    chk("ml_state", 32'(dut.state), 32'(ST_POINT));
    hi_cnt = 0;
    bit0_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.increment_score[1] === 1'b1) hi_cnt++;
      if (bus.increment_score[0] !== 1'b0) bit0_seen = 1'b1;
      tick();
    end
    bus.fsync = 1'b1;
    if (bus.increment_score[1] === 1'b1) hi_cnt++;
    if (bus.increment_score[0] !== 1'b0) bit0_seen = 1'b1;
    tick();
    bus.fsync = 1'b0;
    chk("ml_inc1_cycles", 32'(hi_cnt), 32'd6);
    chk("ml_inc0_never", 32'(bit0_seen), 32'd0);
    chk("ml_inc1_low", 32'(bus.increment_score[1]), 32'd0);
    chk("ml_tally1", 32'(dut.tally[1]), 32'd1);
    chk("ml_dir", 32'(bus.serve_dir), 32'd0);
    chk("ml_after_state", 32'(dut.state), 32'(ST_SERVE));
    serve_to_play();

    bus.miss_left = 1'b1;
    bus.miss_right = 1'b1;
    tick();
    bus.miss_left = 1'b0;
    bus.miss_right = 1'b0;
    chk("both_state", 32'(dut.state), 32'(ST_SERVE));
    chk("both_inc", {30'd0, bus.increment_score[1], bus.increment_score[0]}, 32'd0);
    chk("both_tally0", 32'(dut.tally[0]), 32'd0);
    chk("both_tally1", 32'(dut.tally[1]), 32'd1);
    chk("both_dir", 32'(bus.serve_dir), 32'd0);

    bus.miss_right = 1'b1;
    tick();
    bus.miss_right = 1'b0;
    chk("serve_mr_state", 32'(dut.state), 32'(ST_SERVE));
    chk("serve_mr_tally0", 32'(dut.tally[0]), 32'd0);
    serve_to_play();

    // right miss with fsync on the POINT entry cycle: exactly one increment frame
    bus.miss_right = 1'b1;
    tick();
    bus.miss_right = 1'b0;
    chk("mr_inc0", 32'(bus.increment_score[0]), 32'd1);
    chk("mr_dir", 32'(bus.serve_dir), 32'd1);
    bus.fsync = 1'b1;
    tick();
    bus.fsync = 1'b0;
    chk("mr_inc0_low", 32'(bus.increment_score[0]), 32'd0);
    chk("mr_tally0", 32'(dut.tally[0]), 32'd1);
    chk("mr_state", 32'(dut.state), 32'(ST_SERVE));
    serve_to_play();

    bus.miss_right = 1'b1;
    tick();
    bus.miss_right = 1'b0;
    bus.fsync = 1'b1;
    tick();
    bus.fsync = 1'b0;
    chk("win_game_over", 32'(bus.game_over), 32'd1);
    chk("win_winner", 32'(bus.winner), 32'd0);
    chk("win_tally0", 32'(dut.tally[0]), 32'd2);

    bus.miss_right = 1'b1;
    tick();
    bus.miss_right = 1'b0;
    chk("go_mr_state", 32'(dut.state), 32'(ST_GAME_OVER));
    chk("go_mr_tally0", 32'(dut.tally[0]), 32'd2);
    fsync_pulse();
    fsync_pulse();
    fsync_pulse();
    chk("go_hold", 32'(dut.state), 32'(ST_GAME_OVER));
    bus.fsync = 1'b1;
    tick();
    bus.fsync = 1'b0;
    chk("go_exit_gameover", 32'(bus.game_over), 32'd0);
`ifdef MATCH_CTRL_AUTOSTART_EN
    chk("go_exit_state", 32'(dut.state), 32'(ST_SERVE));
    chk("go_exit_clear", 32'(bus.board_clear), 32'd1);
    chk("go_exit_dir", 32'(bus.serve_dir), 32'd1);
    chk("go_exit_tally0", 32'(dut.tally[0]), 32'd0);
    tick();
`else
    chk("go_exit_state", 32'(dut.state), 32'(ST_IDLE));
    chk("go_exit_clear", 32'(bus.board_clear), 32'd0);
    tick();
    bus.start_btn = 1'b1;
    tick();
    bus.start_btn = 1'b0;
    chk("restart_state", 32'(dut.state), 32'(ST_SERVE));
`endif
    serve_to_play();

    bus.miss_right = 1'b1;
    tick();
    bus.miss_right = 1'b0;
    chk("pre_rst_inc0", 32'(bus.increment_score[0]), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_inc0", 32'(bus.increment_score[0]), 32'd0);
    chk("async_rst_state", 32'(dut.state), 32'(ST_IDLE));
    tick();
    rst = 1'b0;
    tick();
    bus.miss_right = 1'b1;
    tick();
    bus.miss_right = 1'b0;
    chk("idle_mr_state", 32'(dut.state), 32'(ST_IDLE));
    chk("idle_mr_inc0", 32'(bus.increment_score[0]), 32'd0);
    chk("idle_mr_tally0", 32'(dut.tally[0]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/match_controller.md
MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 The block SHALL have parameter SERVE_FRAMES, default 60, frames from serve start to ball release (1..255).
REQ-002 The block SHALL have parameter GAMEOVER_FRAMES, default 180, frames GAME_OVER is held (1..255).
REQ-003 The block SHALL have parameter WIN_SCORE, default 9, points needed to win (1..9).
REQ-004 The block SHALL have port pixel_clk, input, 1, the only clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port fsync, input, 1, one-cycle frame-start pulse.
REQ-007 The block SHALL have port start_btn, input, 1, synchronous level; the block uses its rising edge.
REQ-008 The block SHALL have port miss_left, input, 1, pulse meaning the ball passed the left paddle.
REQ-009 The block SHALL have port miss_right, input, 1, pulse meaning the ball passed the right paddle.
REQ-010 The block SHALL have port increment_score, output, unpacked [1:0], per-player score request to the scoreboard (index 0 = left, 1 = right).
REQ-011 The block SHALL have port board_clear, output, 1, one-cycle pulse that clears the scoreboard.
REQ-012 The block SHALL have port ball_enable, output, 1, high only in PLAY.
REQ-013 The block SHALL have port serve_dir, output, 1, player index the serve travels toward.
REQ-014 The block SHALL have port game_over, output, 1, high in GAME_OVER.
REQ-015 The block SHALL have port winner, output, 1, player index of the last game's winner.

Function
REQ-016 The block SHALL implement the states IDLE, SERVE, PLAY, POINT and GAME_OVER.
REQ-017 IDLE SHALL go on a start_btn rising edge to SERVE: board_clear pulses for 1 cycle, tallies go to 0, serve_dir=0.
REQ-018 SERVE SHALL load the frame timer with SERVE_FRAMES, decrement it on each fsync, and go to PLAY on the cycle after the fsync that reaches 0.
REQ-019 In PLAY, miss_left alone SHALL award a point to player 1, and miss_right alone SHALL award a point to player 0; both go to POINT, and serve_dir is set to the conceding player.
REQ-020 In PLAY, miss_left and miss_right in the same cycle SHALL award no point and go to SERVE with serve_dir unchanged.
REQ-021 miss_left and miss_right SHALL be ignored in every state except PLAY.
REQ-022 In POINT, increment_score[scorer] SHALL be held high from entry up to and including the first cycle with fsync=1, then go low; the scorer's 4-bit tally increments on that same cycle.
REQ-023 If fsync=1 on the POINT entry cycle, that cycle SHALL count, giving exactly one frame of increment.
REQ-024 After the increment, if tally == WIN_SCORE the block SHALL go to GAME_OVER with winner=scorer; otherwise it goes to SERVE.
REQ-025 GAME_OVER SHALL hold for GAMEOVER_FRAMES fsync pulses, then exit as defined in REQ-031/REQ-032.
REQ-026 At most one increment_score bit SHALL be high in any cycle, and it is never high outside POINT.
REQ-027 start_btn edges SHALL be ignored outside IDLE.

Reset
REQ-028 While rst is high, the block SHALL hold state IDLE, all tallies 0, the timer 0, and the start_btn edge register 0.
REQ-029 While rst is high, the outputs SHALL be: increment_score='{0,0}, board_clear=0, ball_enable=0, serve_dir=0, game_over=0, winner=0.
REQ-030 rst asserted mid-POINT SHALL drop increment_score in the same cycle, asynchronously.

Configuration
REQ-031 When macro MATCH_CTRL_AUTOSTART_EN is defined, GAME_OVER expiry SHALL pulse board_clear, clear the tallies, set serve_dir=!winner, and go directly to SERVE.
REQ-032 When MATCH_CTRL_AUTOSTART_EN is undefined, GAME_OVER expiry SHALL go to IDLE and wait for start_btn; the reset state is IDLE in both builds.

Structure
REQ-033 Shared package pong_pkg SHALL hold the match_state_t enum, the PLAYER_L=0 and PLAYER_R=1 constants, and the default frame counts.
REQ-034 A sub-module frame_timer SHALL provide the 8-bit load, decrement-on-fsync, and done flag; it is reused for SERVE and GAME_OVER.

Verification
REQ-035 Reset, start_btn edge, SERVE_FRAMES=3 -> board_clear 1 cycle; ball_enable rises the cycle after the 3rd fsync.
REQ-036 PLAY, miss_left pulse, fsync arrives 5 cycles later -> increment_score[1] high 6 cycles, bit 0 never high, tally1=1, serve_dir=0, state SERVE.
REQ-037 PLAY, miss_left and miss_right in the same cycle -> no increment, state SERVE, tallies unchanged.
REQ-038 WIN_SCORE=2, player 0 scores twice -> game_over=1, winner=0; after GAMEOVER_FRAMES fsyncs the state is IDLE (macro off), or SERVE with board_clear and serve_dir=1 (macro on).
REQ-039 rst asserted during POINT with increment_score[0]=1 -> output 0 immediately, state IDLE; a later miss_right is ignored until the next start.
REQ-040 miss_right during SERVE or GAME_OVER, and start_btn during PLAY -> no state or output change.
